// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared types and constants for the USB data buffer slice.
//   BUFFER_DEPTH : number of byte entries in the data buffer
//   usb_byte_t   : one byte of USB payload
//   occ_t        : buffer occupancy (0..BUFFER_DEPTH)
// ---------------------------------------------------------------------------
package usb_pkg;

    localparam int BUFFER_DEPTH = 64;

    typedef logic [7:0] usb_byte_t;
    typedef logic [6:0] occ_t;

endpackage

// File: rtl/usb_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// usb_buffer_ctrl
// Pointer and occupancy bookkeeping for the USB data buffer. Decides which
// push/pop requests actually take effect and gives flush priority over both.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   wr, rd      : merged push / pop requests
//   flush_req   : synchronous empty request (flush | clear)
//   wptr, rptr  : write / read pointers into the storage array
//   do_wr       : a byte is written to mem[wptr] at this edge
//   count       : registered entry count, 0..DEPTH
// ---------------------------------------------------------------------------
module usb_buffer_ctrl #(
    parameter int DEPTH = 64,
    parameter int OCC_W = 7,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr,
    input  logic             rd,
    input  logic             flush_req,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic             do_wr,
    output logic [OCC_W-1:0] count
);

    logic do_rd;
    logic is_empty;
    logic is_full;

    assign is_empty = (count == '0);
    assign is_full  = (count == OCC_W'(DEPTH));

    // A pop is honoured only when there is data; a push while full only
    // succeeds if a pop frees the slot in the same cycle. Flush suppresses
    // the array write so discarded stores never touch storage.
    always_comb begin
        do_rd = rd && !is_empty && !flush_req;
        do_wr = wr && (!is_full || (rd && !is_empty)) && !flush_req;
    end

    // Pointers wrap naturally at DEPTH because PTR_W = log2(DEPTH).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_req) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_rd) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usb_data_buffer.sv
// ---------------------------------------------------------------------------
// usb_data_buffer
// First-word-fall-through byte FIFO shared by usb_rx, usb_tx and the host
// side. Two push sources (rx wins when both push) and two pop sources (a
// simultaneous pop from both is a single pop).
// Ports:
//   clk, n_rst                         : clock, asynchronous active-low reset
//   store_rx_packet_data, rx_packet_data : push from usb_rx
//   store_tx_data, tx_data             : push from host side
//   get_rx_data, get_tx_packet_data    : pop requests (host / usb_tx)
//   flush, clear                       : synchronous empty requests
//   buffer_occupancy                   : registered entry count
//   rx_data, tx_packet_data            : head byte (0x00 when empty)
// ---------------------------------------------------------------------------
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = BUFFER_DEPTH,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    input  logic             get_tx_packet_data,
    input  logic             flush,
    input  logic             clear,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic [7:0]       rx_data,
    output logic [7:0]       tx_packet_data
);

    localparam int PTR_W = $clog2(DEPTH);

    usb_byte_t        mem [DEPTH];
    usb_byte_t        wr_data;
    usb_byte_t        head;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_wr;
    logic [OCC_W-1:0] count;

    usb_buffer_ctrl #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr        (store_rx_packet_data | store_tx_data),
        .rd        (get_rx_data | get_tx_packet_data),
        .flush_req (flush | clear),
        .wptr      (wptr),
        .rptr      (rptr),
        .do_wr     (do_wr),
        .count     (count)
    );

    // The rx byte takes precedence; tx_data is dropped when both push.
    assign wr_data = store_rx_packet_data ? rx_packet_data : tx_data;

    // Storage has no reset: emptiness is tracked by count alone, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    // Head byte is shown before the pop; forced to zero when empty.
    assign head = (count != '0) ? mem[rptr] : 8'h00;

    assign buffer_occupancy = count;
    assign rx_data          = head;
    assign tx_packet_data   = head;

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

64-byte single-storage FIFO that sits directly downstream of `usb_rx` and alongside `usb_tx`. It accepts bytes from `usb_rx` (`store_rx_packet_data`/`rx_packet_data`) and from the host-side interface (`store_tx_data`/`tx_data`). It serves reads to the host side (`get_rx_data`) and to `usb_tx` (`get_tx_packet_data`). Its `buffer_occupancy` output feeds back to `usb_rx` and `usb_tx`, so they can detect full, empty and oversize conditions.

## Interface
Parameters:
- `DEPTH`, default 64: number of byte entries; must be a power of two.
- `OCC_W`, default 7: occupancy width, equal to $clog2(DEPTH)+1.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `n_rst`, input, 1: reset; one clock; reset is asynchronous and active-low.
- `store_rx_packet_data`, input, 1: push `rx_packet_data` this cycle (from `usb_rx`).
- `rx_packet_data`, input, 8: byte from `usb_rx`.
- `store_tx_data`, input, 1: push `tx_data` this cycle (host side).
- `tx_data`, input, 8: byte from host side.
- `get_rx_data`, input, 1: pop head byte (host side).
- `get_tx_packet_data`, input, 1: pop head byte (`usb_tx`).
- `flush`, input, 1: synchronous empty request from `usb_rx`/`usb_tx`.
- `clear`, input, 1: synchronous empty request from host side.
- `buffer_occupancy`, output, 7: current entry count, 0..64, registered.
- `rx_data`, output, 8: head byte for the host side.
- `tx_packet_data`, output, 8: head byte for `usb_tx` (same value as `rx_data`).

## Operation
- Storage: 64 x 8 register array. Pointers `wptr` and `rptr` are 6 bits each and wrap naturally from 63 to 0. `count` is 7 bits and drives `buffer_occupancy` directly.
- Write request `wr = store_rx_packet_data | store_tx_data`.
  - Write data is `rx_packet_data` when `store_rx_packet_data` is set, otherwise `tx_data`.
  - If both stores are asserted, the rx byte wins and `tx_data` is dropped.
- Read request `rd = get_rx_data | get_tx_packet_data`. Both asserted in the same cycle is a single pop.
- Effective operations:
  - `do_rd = rd & (count != 0)`.
  - `do_wr = wr & ((count != 64) | do_rd)`. A write while full succeeds only when paired with a read in the same cycle.
  - `do_rd` advances `rptr`. `do_wr` writes `mem[wptr]` and advances `wptr`.
  - `count` next value is `count + do_wr - do_rd`. It never leaves the range 0..64.
- Ignored requests:
  - Write while full with no read: dropped, no state change.
  - Read while empty: ignored, and the outputs keep showing 0x00.
- Flush/clear: if `flush | clear` is sampled high, the next state is `wptr = rptr = count = 0`.
  - This has priority over any write or read in the same cycle; those requests are discarded.
  - Array contents are not cleared.
- Read data is first-word-fall-through:
  - `rx_data = tx_packet_data = (count != 0) ? mem[rptr] : 8'h00`.
  - The head byte is visible before the pop request. The pop takes effect at the clock edge.

## Timing
- Reset (async, `n_rst` low): `wptr = rptr = 0`, `count = 0`, `buffer_occupancy = 0`, `rx_data = tx_packet_data = 8'h00`. Reset asserted mid-packet discards all contents immediately.
- Write latency: the byte stored at edge N is visible on `rx_data` in the cycle after edge N when the FIFO was empty. `buffer_occupancy` increments after edge N.
- Read: `rx_data` shows the new head (or 0x00 when it becomes empty) in the cycle after the pop edge.
- Simultaneous push and pop:
  - Empty: the push succeeds, the pop is ignored, and `count` goes 0 -> 1.
  - Full: both succeed and `count` stays 64.
  - Otherwise: `count` is unchanged and both pointers advance.
- Flush: `buffer_occupancy` reads 0 in the cycle after the flush edge. A store in the cycle after that is accepted normally.
- `usb_rx` drives `store_rx_packet_data` at most once per 8 bit times, so no back-pressure handshake exists. Overflow is detected by `usb_rx` from `buffer_occupancy`.

## Structure
- Package `usb_pkg` holds:
  - `localparam BUFFER_DEPTH = 64`.
  - `typedef logic [7:0] usb_byte_t`.
  - `typedef logic [6:0] occ_t`.
- One sub-module, `usb_buffer_ctrl`:
  - Contains the pointers, `count`, the `do_rd`/`do_wr` arbitration and the flush priority.
  - Outputs `wptr`, `rptr`, `do_wr`, `count`.
- The top level holds the storage array, the write-data mux and the head-read mux.

## Test plan
- Reset then idle: occupancy 0, both data outputs 0x00. Push rx bytes 0x01, 0xCA, 0x70 -> occupancy 3 and `rx_data` = 0x01. After three `get_rx_data` pops -> 0xCA, 0x70, then 0x00 with occupancy 0.
- Fill 64 bytes via `store_tx_data` (values 0..63) -> occupancy 64. A 65th push (0xFF) is dropped. Pop all via `get_tx_packet_data` -> 0..63 in order, with the pointers wrapping.
- While full, push 0xAA together with `get_tx_packet_data` -> occupancy stays 64. After draining, the last byte read is 0xAA.
- Empty with simultaneous push 0x55 and pop -> occupancy 1 and `rx_data` = 0x55. Both stores in one cycle (rx 0x11, tx 0x22) -> only 0x11 is stored.
- Load 10 bytes, then assert `flush` together with a store -> occupancy 0 next cycle and the store is discarded. Repeat the same with `clear`. A subsequent push of 0x3C reads back as 0x3C.
- Load 5 bytes, assert `n_rst` asynchronously mid-cycle -> occupancy 0 and outputs 0x00 immediately, without waiting for a clock edge.
